// File: rtl/packet_arbiter_if.sv
// packet_arbiter_if
//   Bundles the per-source beat streams feeding packet_arbiter and the single
//   merged stream it drives towards payload_aligner.
//
//   src_valid       per-port beat valid
//   src_packet      per-port data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   src_sop         per-port start of packet
//   src_eop         per-port end of packet
//   src_byte_enable per-port byte enables, port i at [i*BE_WIDTH +: BE_WIDTH]
//   src_ready       per-port accept (beat moves when src_valid & src_ready)
//   dst_valid       merged beat valid
//   dst_packet      merged data
//   dst_sop         merged start of packet
//   dst_eop         merged end of packet
//   dst_byte_enable merged byte enables
//   dst_grant       port that sourced the current merged beat
//   err_count       saturating protocol-error count
//
//   slave  : the arbiter side
//   master : the source / sink side (testbench or surrounding logic)
interface packet_arbiter_if #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 64,
  parameter int BE_WIDTH   = 8
);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0]            src_valid;
  logic [NUM_PORTS*DATA_WIDTH-1:0] src_packet;
  logic [NUM_PORTS-1:0]            src_sop;
  logic [NUM_PORTS-1:0]            src_eop;
  logic [NUM_PORTS*BE_WIDTH-1:0]   src_byte_enable;
  logic [NUM_PORTS-1:0]            src_ready;

  logic                            dst_valid;
  logic [DATA_WIDTH-1:0]           dst_packet;
  logic                            dst_sop;
  logic                            dst_eop;
  logic [BE_WIDTH-1:0]             dst_byte_enable;
  logic [PW-1:0]                   dst_grant;
  logic [15:0]                     err_count;

  modport slave (
    input  src_valid, src_packet, src_sop, src_eop, src_byte_enable,
    output src_ready,
    output dst_valid, dst_packet, dst_sop, dst_eop, dst_byte_enable,
    output dst_grant, err_count
  );

  modport master (
    output src_valid, src_packet, src_sop, src_eop, src_byte_enable,
    input  src_ready,
    input  dst_valid, dst_packet, dst_sop, dst_eop, dst_byte_enable,
    input  dst_grant, err_count
  );
endinterface

// File: rtl/packet_arbiter.sv
// packet_arbiter
//   Packet-granular round-robin arbiter merging NUM_PORTS beat streams onto
//   one stream. The downstream consumer has no backpressure, so every beat
//   accepted here appears on the output exactly one cycle later.
//
//   clk    clock, all logic on the rising edge
//   rst_b  synchronous reset, active-low; also forces every ready low
//   bus    packet_arbiter_if.slave (source streams in, merged stream out)
//
//   state  | meaning
//   IDLE   | no owner; pick next sop at/after ptr, swallow orphan beats
//   LOCKED | owner holds the output until its eop beat is accepted
module packet_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 64,
  parameter int BE_WIDTH   = 8
) (
  input  logic            clk,
  input  logic            rst_b,
  packet_arbiter_if.slave bus
);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]            state;
  logic [PW-1:0]         ptr;
  logic [PW-1:0]         owner;

  logic [NUM_PORTS-1:0]  cand;
  logic [NUM_PORTS-1:0]  orphan;
  logic                  found;
  logic [PW-1:0]         winner;

  logic [NUM_PORTS-1:0]  ready;
  logic                  fwd;
  logic [PW-1:0]         sel;
  logic                  err_hit;

  logic [DATA_WIDTH-1:0] sel_packet;
  logic [BE_WIDTH-1:0]   sel_be;
  logic                  sel_sop;
  logic                  sel_eop;

  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_packet;
  logic                  out_sop;
  logic                  out_eop;
  logic [BE_WIDTH-1:0]   out_be;
  logic [PW-1:0]         out_grant;
  logic [15:0]           err_count;

  assign cand   = bus.src_valid & bus.src_sop;
  assign orphan = bus.src_valid & ~bus.src_sop;

  // First sop candidate at or after ptr, wrapping around the port list.
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = (int'(ptr) + k) % NUM_PORTS;
      if (!found && cand[idx[PW-1:0]]) begin
        found  = 1'b1;
        winner = idx[PW-1:0];
      end
    end
  end

  // In IDLE the winner and every orphan are accepted in the same cycle;
  // orphans are dropped, so at most one beat is forwarded per cycle.
  always_comb begin
    ready   = '0;
    fwd     = 1'b0;
    sel     = owner;
    err_hit = 1'b0;
    if (rst_b) begin
      if (state == ST_IDLE) begin
        ready   = orphan;
        err_hit = |orphan;
        if (found) begin
          ready[winner] = 1'b1;
          fwd           = 1'b1;
          sel           = winner;
        end
      end else begin
        ready[owner] = 1'b1;
        if (bus.src_valid[owner]) begin
          fwd     = 1'b1;
          err_hit = bus.src_sop[owner];
        end
      end
    end
  end

  assign sel_packet = bus.src_packet[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_be     = bus.src_byte_enable[int'(sel)*BE_WIDTH +: BE_WIDTH];
  assign sel_sop    = bus.src_sop[sel];
  assign sel_eop    = bus.src_eop[sel];

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      owner      <= '0;
      out_valid  <= 1'b0;
      out_packet <= '0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      out_be     <= '0;
      out_grant  <= '0;
      err_count  <= '0;
    end else begin
      out_valid <= fwd;
      out_sop   <= fwd & sel_sop;
      out_eop   <= fwd & sel_eop;
      if (fwd) begin
        out_packet <= sel_packet;
        out_be     <= sel_be;
        out_grant  <= sel;
      end

      if (err_hit && (err_count != 16'hFFFF)) begin
        err_count <= err_count + 16'd1;
      end

      case (state)
        ST_IDLE: begin
          if (found) begin
            ptr   <= (winner == PW'(NUM_PORTS - 1)) ? '0 : winner + 1'b1;
            owner <= winner;
            if (!sel_eop) begin
              state <= ST_LOCKED;
            end
          end
        end
        ST_LOCKED: begin
          if (fwd && sel_eop) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.src_ready       = ready;
  assign bus.dst_valid       = out_valid;
  assign bus.dst_packet      = out_packet;
  assign bus.dst_sop         = out_sop;
  assign bus.dst_eop         = out_eop;
  assign bus.dst_byte_enable = out_be;
  assign bus.dst_grant       = out_grant;
  assign bus.err_count       = err_count;
endmodule

// File: tb/tb_packet_arbiter.sv
// tb_packet_arbiter
//   Drives packet_arbiter through a vector table, hand-written corner-case
//   sequences and random traffic; a cycle-level reference model built on an
//   integer "owner" and a round-robin pointer checks every cycle.
module tb_packet_arbiter;
  localparam int NP = 4;
  localparam int DW = 64;
  localparam int BW = 8;

  logic clk;
  logic rst_b;

  packet_arbiter_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .BE_WIDTH(BW)) bus ();

  packet_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .BE_WIDTH(BW)) dut (
    .clk  (clk),
    .rst_b(rst_b),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] d [NP];
  logic [BW-1:0] b [NP];
  logic [NP-1:0] rdy_s;

  // reference model state
  int            m_owner;   // -1: nobody owns the output
  int            m_ptr;
  int            m_err;
  logic [NP-1:0] m_ready;
  logic          e_valid, e_sop, e_eop;
  logic [DW-1:0] e_data;
  logic [BW-1:0] e_be;
  int            e_grant;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NP-1:0] c);
    for (int k = 0; k < NP; k++) begin
      if (c[(m_ptr + k) % NP]) return (m_ptr + k) % NP;
    end
    return -1;
  endfunction

  function automatic logic [NP-1:0] model_ready(input logic r, input logic [NP-1:0] v, input logic [NP-1:0] s);
    logic [NP-1:0] rd;
    int w;
    rd = '0;
    if (!r) return rd;
    if (m_owner < 0) begin
      rd = v & ~s;
      w  = pick(v & s);
      if (w >= 0) rd[w] = 1'b1;
    end else begin
      rd[m_owner] = 1'b1;
    end
    return rd;
  endfunction

  function automatic void model_edge(input logic r, input logic [NP-1:0] v, input logic [NP-1:0] s, input logic [NP-1:0] e);
    int f;
    int w;
    f = -1;
    if (!r) begin
      m_owner = -1; m_ptr = 0; m_err = 0;
      e_valid = 0; e_sop = 0; e_eop = 0; e_data = '0; e_be = '0; e_grant = 0;
      return;
    end
    if (m_owner < 0) begin
      if ((v & ~s) != '0 && m_err < 65535) m_err++;
      w = pick(v & s);
      if (w >= 0) begin
        f       = w;
        m_ptr   = (w + 1) % NP;
        m_owner = e[w] ? -1 : w;
      end
    end else if (v[m_owner]) begin
      f = m_owner;
      if (s[f] && m_err < 65535) m_err++;
      if (e[f]) m_owner = -1;
    end
    e_valid = (f >= 0);
    e_sop   = (f >= 0) && s[f];
    e_eop   = (f >= 0) && e[f];
    if (f >= 0) begin
      e_data  = d[f];
      e_be    = b[f];
      e_grant = f;
    end
  endfunction

  // One clock cycle: drive on the falling edge, check ready just before the
  // rising edge, check registered outputs 1ns after it.
  task automatic step(input logic r, input logic [NP-1:0] v, input logic [NP-1:0] s, input logic [NP-1:0] e);
    @(negedge clk);
    rst_b         = r;
    bus.src_valid = v;
    bus.src_sop   = s;
    bus.src_eop   = e;
    for (int i = 0; i < NP; i++) begin
      bus.src_packet[i*DW +: DW]    = d[i];
      bus.src_byte_enable[i*BW +: BW] = b[i];
    end
    #2;
    m_ready = model_ready(r, v, s);
    rdy_s   = bus.src_ready;
    chk("model_ready", 64'(bus.src_ready), 64'(m_ready));
    model_edge(r, v, s, e);
    @(posedge clk);
    #1;
    chk("model_valid", 64'(bus.dst_valid), 64'(e_valid));
    chk("model_sop",   64'(bus.dst_sop),   64'(e_sop));
    chk("model_eop",   64'(bus.dst_eop),   64'(e_eop));
    chk("model_data",  bus.dst_packet,     e_data);
    chk("model_be",    64'(bus.dst_byte_enable), 64'(e_be));
    chk("model_grant", 64'(bus.dst_grant), 64'(e_grant));
    chk("model_err",   64'(bus.err_count), 64'(m_err));
  endtask

  task automatic do_reset();
    step(1'b0, '0, '0, '0);
    step(1'b0, '0, '0, '0);
  endtask

  typedef struct {
    logic          r;
    logic [NP-1:0] v, s, e;
    logic [NP-1:0] rdy;
    logic          ov;
    logic [1:0]    g;
    logic [15:0]   err;
  } vec_t;

  vec_t tbl [13];

  initial begin
    rst_b = 1'b0;
    bus.src_valid = '0; bus.src_sop = '0; bus.src_eop = '0;
    bus.src_packet = '0; bus.src_byte_enable = '0;
    m_owner = -1; m_ptr = 0; m_err = 0;
    e_valid = 0; e_sop = 0; e_eop = 0; e_data = '0; e_be = '0; e_grant = 0;
    for (int i = 0; i < NP; i++) begin
      d[i] = 64'h1000 * 64'(i + 1);
      b[i] = 8'(8'h11 * (i + 1));
    end

    // ---------------- vector table ----------------
    //            r     valid    sop      eop      ready    ov  g     err
    tbl[0]  = '{1'b0, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 0, 2'd0, 16'd0};
    tbl[1]  = '{1'b0, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 0, 2'd0, 16'd0};
    tbl[2]  = '{1'b1, 4'b1111, 4'b1111, 4'b1111, 4'b0001, 1, 2'd0, 16'd0};
    tbl[3]  = '{1'b1, 4'b1111, 4'b1111, 4'b1111, 4'b0010, 1, 2'd1, 16'd0};
    tbl[4]  = '{1'b1, 4'b0101, 4'b0101, 4'b0000, 4'b0100, 1, 2'd2, 16'd0};
    tbl[5]  = '{1'b1, 4'b1111, 4'b0011, 4'b0000, 4'b0100, 1, 2'd2, 16'd0};
    tbl[6]  = '{1'b1, 4'b1011, 4'b1011, 4'b0000, 4'b0100, 0, 2'd2, 16'd0};
    tbl[7]  = '{1'b1, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 1, 2'd2, 16'd1};
    tbl[8]  = '{1'b1, 4'b0110, 4'b0010, 4'b0100, 4'b0100, 1, 2'd2, 16'd1};
    tbl[9]  = '{1'b1, 4'b1010, 4'b0000, 4'b0000, 4'b1010, 0, 2'd2, 16'd2};
    tbl[10] = '{1'b1, 4'b1011, 4'b0001, 4'b0001, 4'b1011, 1, 2'd0, 16'd3};
    tbl[11] = '{1'b1, 4'b1001, 4'b1001, 4'b1001, 4'b1000, 1, 2'd3, 16'd3};
    tbl[12] = '{1'b1, 4'b1001, 4'b1001, 4'b1001, 4'b0001, 1, 2'd0, 16'd3};
    for (int t = 0; t < 13; t++) begin
      step(tbl[t].r, tbl[t].v, tbl[t].s, tbl[t].e);
      chk($sformatf("tbl%0d_ready", t), 64'(rdy_s), 64'(tbl[t].rdy));
      chk($sformatf("tbl%0d_valid", t), 64'(bus.dst_valid), 64'(tbl[t].ov));
      chk($sformatf("tbl%0d_grant", t), 64'(bus.dst_grant), 64'(tbl[t].g));
      chk($sformatf("tbl%0d_err", t),   64'(bus.err_count), 64'(tbl[t].err));
    end

    // ---------------- fairness: 3-beat packets from all ports ----------------
    begin
      int beat [NP];
      logic [NP-1:0] s, e;
      do_reset();
      for (int i = 0; i < NP; i++) beat[i] = 0;
      for (int c = 0; c < 12; c++) begin
        for (int i = 0; i < NP; i++) begin
          s[i] = (beat[i] == 0);
          e[i] = (beat[i] == 2);
          d[i] = 64'((i << 8) | beat[i]);
        end
        step(1'b1, 4'b1111, s, e);
        chk("fair_valid", 64'(bus.dst_valid), 64'd1);
        chk("fair_grant", 64'(bus.dst_grant), 64'(c / 3));
        chk("fair_data",  bus.dst_packet, 64'(((c / 3) << 8) | (c % 3)));
        for (int i = 0; i < NP; i++) if (rdy_s[i]) beat[i] = (beat[i] + 1) % 3;
      end
    end

    // ---------------- lock hold across a valid gap ----------------
    do_reset();
    d[2] = 64'hA2A2; d[1] = 64'hB1B1;
    step(1'b1, 4'b0100, 4'b0100, 4'b0000);
    chk("lock_sop_grant", 64'(bus.dst_grant), 64'd2);
    for (int g = 0; g < 4; g++) begin
      step(1'b1, 4'b0010, 4'b0010, 4'b0010);
      chk("lock_gap_ready1", 64'(rdy_s[1]), 64'd0);
      chk("lock_gap_valid",  64'(bus.dst_valid), 64'd0);
    end
    d[2] = 64'hE2E2;
    step(1'b1, 4'b0110, 4'b0010, 4'b0110);
    chk("lock_eop_ready1", 64'(rdy_s[1]), 64'd0);
    chk("lock_eop_out",    64'(bus.dst_eop), 64'd1);
    step(1'b1, 4'b0010, 4'b0010, 4'b0010);
    chk("lock_next_ready1", 64'(rdy_s[1]), 64'd1);
    chk("lock_next_grant",  64'(bus.dst_grant), 64'd1);
    chk("lock_next_data",   bus.dst_packet, 64'hB1B1);

    // ---------------- single-beat back-to-back ----------------
    do_reset();
    for (int c = 0; c < 8; c++) begin
      step(1'b1, 4'b1001, 4'b1001, 4'b1001);
      chk("b2b_valid", 64'(bus.dst_valid), 64'd1);
      chk("b2b_grant", 64'(bus.dst_grant), (c % 2 == 0) ? 64'd0 : 64'd3);
      chk("b2b_sopeop", 64'({bus.dst_sop, bus.dst_eop}), 64'd3);
    end

    // ---------------- orphans and saturation ----------------
    do_reset();
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 4'b0010, 4'b0000, 4'b0000);
      chk("orph_drop", 64'(bus.dst_valid), 64'd0);
    end
    chk("orph_err5", 64'(bus.err_count), 64'd5);
    d[1] = 64'hCAFE_0001;
    step(1'b1, 4'b0010, 4'b0010, 4'b0000);
    chk("orph_pkt_sop", bus.dst_packet, 64'hCAFE_0001);
    d[1] = 64'hCAFE_0002;
    step(1'b1, 4'b0010, 4'b0000, 4'b0010);
    chk("orph_pkt_eop",  bus.dst_packet, 64'hCAFE_0002);
    chk("orph_pkt_err",  64'(bus.err_count), 64'd5);
    for (int c = 0; c < 65540; c++) step(1'b1, 4'b0010, 4'b0000, 4'b0000);
    chk("orph_sat", 64'(bus.err_count), 64'hFFFF);

    // ---------------- reset mid-packet ----------------
    do_reset();
    step(1'b1, 4'b0001, 4'b0001, 4'b0000);
    step(1'b1, 4'b0001, 4'b0000, 4'b0000);
    step(1'b0, 4'b0001, 4'b0000, 4'b0000);
    chk("rmid_ready_in_reset", 64'(rdy_s), 64'd0);
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 4'b0001, 4'b0000, (c == 2) ? 4'b0001 : 4'b0000);
      chk("rmid_no_fwd", 64'(bus.dst_valid), 64'd0);
    end
    chk("rmid_err3", 64'(bus.err_count), 64'd3);
    d[0] = 64'h5A5A;
    step(1'b1, 4'b0001, 4'b0001, 4'b0001);
    chk("rmid_new_pkt", 64'({bus.dst_valid, bus.dst_sop, bus.dst_eop}), 64'd7);
    chk("rmid_new_data", bus.dst_packet, 64'h5A5A);

    // ---------------- random traffic ----------------
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [NP-1:0] v, s, e;
      for (int i = 0; i < NP; i++) begin
        v[i] = ($urandom_range(0, 9) < 7);
        s[i] = ($urandom_range(0, 9) < 3);
        e[i] = ($urandom_range(0, 9) < 4);
        d[i] = {$urandom, $urandom};
        b[i] = 8'($urandom);
      end
      step(($urandom_range(0, 199) != 0), v, s, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
